// File: rtl/accum_pkg.sv
// Shared types for the accumulation engine.
//   state_e : engine FSM states (IDLE / RUN / DONE)
//   op_e    : run operation selected by op_i (SUM / MAX / MIN / SAT)
package accum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_SUM = 2'd0,
    OP_MAX = 2'd1,
    OP_MIN = 2'd2,
    OP_SAT = 2'd3
  } op_e;

endpackage : accum_pkg

// File: rtl/sat_add.sv
// ACC_W-bit unsigned adder with carry-out and optional clamp to all-ones.
// Ports:
//   a, b    : addends
//   sat     : clamp the sum to 2^ACC_W-1 when the add carries out
//   sum_c   : wrapped or clamped sum (combinational)
//   carry_c : carry-out of the raw add (combinational)
module sat_add #(
  parameter int unsigned ACC_W = 16
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  input  logic             sat,
  output logic [ACC_W-1:0] sum_c,
  output logic             carry_c
);

  logic [ACC_W:0] full;

  always_comb begin
    full    = {1'b0, a} + {1'b0, b};
    carry_c = full[ACC_W];
    sum_c   = (sat && carry_c) ? '1 : full[ACC_W-1:0];
  end

endmodule : sat_add

// File: rtl/accum_engine.sv
// Streaming accumulator: after start_i, consumes n_i samples through a
// valid/ready handshake and reduces them by SUM, MAX, MIN or saturating SUM.
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   start_i, op_i, n_i: run request, operation, sample count (IDLE/DONE only)
//   valid_i, data_i   : sample stream
//   ready_o           : sample accepted this cycle when valid_i=1 (RUN only)
//   busy_o            : run in progress
//   done_o            : result valid, held until next start or reset
//   result_o          : accumulator register (intermediate values during RUN)
//   ovf_o             : sticky wrap/saturation flag for the current run
module accum_engine
  import accum_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned ACC_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [CNT_W-1:0]  n_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [ACC_W-1:0]  result_o,
  output logic              ovf_o
);

  state_e             state;
  op_e                op_q;
  logic [CNT_W-1:0]   n_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ACC_W-1:0]   acc_q;
  logic               ovf_q;
  logic               done_q;
  logic               busy_q;
  logic               ready_q;

  logic [ACC_W-1:0]   sample_ext;
  logic [ACC_W-1:0]   add_sum;
  logic               add_carry;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               accept;
  logic               first;

  assign sample_ext = ACC_W'(data_i);
  assign cnt_nxt    = cnt_q + CNT_W'(1);
  assign accept     = valid_i && ready_q;
  // MAX/MIN load the first sample unconditionally instead of comparing to 0.
  assign first      = (cnt_q == '0);

  sat_add #(
    .ACC_W (ACC_W)
  ) u_sat_add (
    .a       (acc_q),
    .b       (sample_ext),
    .sat     (op_q == OP_SAT),
    .sum_c   (add_sum),
    .carry_c (add_carry)
  );

  // Engine FSM; every output is a register updated here.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      op_q    <= OP_SUM;
      n_q     <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            op_q  <= op_e'(op_i);
            n_q   <= n_i;
            cnt_q <= '0;
            acc_q <= '0;
            ovf_q <= 1'b0;
            if (n_i == '0) begin
              // Empty run completes immediately with a zero result.
              state   <= ST_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              ready_q <= 1'b0;
            end else begin
              state   <= ST_RUN;
              done_q  <= 1'b0;
              busy_q  <= 1'b1;
              ready_q <= 1'b1;
            end
          end
        end

        ST_RUN: begin
          if (accept) begin
            cnt_q <= cnt_nxt;
            case (op_q)
              OP_SUM, OP_SAT: begin
                acc_q <= add_sum;
                if (add_carry) ovf_q <= 1'b1;
              end
              OP_MAX: if (first || (sample_ext > acc_q)) acc_q <= sample_ext;
              OP_MIN: if (first || (sample_ext < acc_q)) acc_q <= sample_ext;
              default: acc_q <= acc_q;
            endcase
            if (cnt_nxt == n_q) begin
              state   <= ST_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              ready_q <= 1'b0;
            end
          end
        end

        default: begin
          state   <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o  = ready_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = acc_q;
  assign ovf_o    = ovf_q;

endmodule : accum_engine

// File: tb/tb_accum_engine.sv
// Self-checking bench for accum_engine (ACC_W=8 so overflow is easy to reach).
module tb_accum_engine;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 8;
  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    op_in;
  logic [CW-1:0] n_in;
  logic          valid;
  logic [DW-1:0] data;
  logic          ready;
  logic          busy;
  logic          done;
  logic [AW-1:0] result;
  logic          ovf;

  int total = 0;
  int bad   = 0;
  int unsigned samp[$];

  always #5 clk = ~clk;

  accum_engine #(
    .DATA_W (DW),
    .CNT_W  (CW),
    .ACC_W  (AW)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .op_i     (op_in),
    .n_i      (n_in),
    .valid_i  (valid),
    .data_i   (data),
    .ready_o  (ready),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result),
    .ovf_o    (ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: reduce the first k entries of samp with plain integer math.
  function automatic void model(input int op, input int k, output int res, output bit o);
    int t;
    t = 0;
    res = 0;
    o = 1'b0;
    for (int i = 0; i < k; i++) begin
      int v;
      v = int'(samp[i]);
      case (op)
        1: res = (i == 0 || v > res) ? v : res;
        2: res = (i == 0 || v < res) ? v : res;
        default: t = t + v;
      endcase
    end
    if (op == 0) begin
      res = t % 256;
      o   = (t > 255);
    end else if (op == 3) begin
      res = (t > 255) ? 255 : t;
      o   = (t > 255);
    end
  endfunction

  // Start a run over samp[0..n-1]; gap<0 picks random stalls of 0..2 cycles.
  task automatic do_run(input int op, input int n, input int gap, input string tag);
    int r;
    bit o;
    int g;
    bit last;
    start = 1'b1;
    op_in = 2'(op);
    n_in  = CW'(n);
    tick();
    start = 1'b0;
    total++;
    if (n == 0) begin
      if (done !== 1'b1 || busy !== 1'b0 || ready !== 1'b0 || result !== '0 || ovf !== 1'b0) begin
        bad++;
        $display("FAIL %s zero_len: done=%0b busy=%0b ready=%0b result=%0d ovf=%0b want 1 0 0 0 0",
                 tag, done, busy, ready, result, ovf);
      end
      return;
    end
    if (done !== 1'b0 || busy !== 1'b1 || ready !== 1'b1 || result !== '0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL %s start: done=%0b busy=%0b ready=%0b result=%0d ovf=%0b want 0 1 1 0 0",
               tag, done, busy, ready, result, ovf);
    end
    for (int k = 0; k < n; k++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      repeat (g) begin
        valid = 1'b0;
        data  = DW'($urandom);
        start = ($urandom_range(0, 3) == 0);
        tick();
        start = 1'b0;
        model(op, k, r, o);
        total++;
        if (result !== AW'(r) || ovf !== o || busy !== 1'b1 || ready !== 1'b1 || done !== 1'b0) begin
          bad++;
          $display("FAIL %s stall k=%0d: result=%0d ovf=%0b busy=%0b ready=%0b done=%0b want %0d %0b 1 1 0",
                   tag, k, result, ovf, busy, ready, done, r, o);
        end
      end
      valid = 1'b1;
      data  = DW'(samp[k]);
      tick();
      valid = 1'b0;
      model(op, k + 1, r, o);
      last = (k == n - 1);
      total++;
      if (result !== AW'(r) || ovf !== o || done !== last || busy !== !last || ready !== !last) begin
        bad++;
        $display("FAIL %s sample k=%0d: result=%0d ovf=%0b done=%0b busy=%0b ready=%0b want %0d %0b %0b %0b %0b",
                 tag, k, result, ovf, done, busy, ready, r, o, last, !last, !last);
      end
    end
  endtask

  // Idle in DONE with stray valid/data; result must hold.
  task automatic hold_done(input int op, input int n, input int cycles, input string tag);
    int r;
    bit o;
    model(op, n, r, o);
    repeat (cycles) begin
      valid = 1'($urandom);
      data  = DW'($urandom);
      tick();
      valid = 1'b0;
      total++;
      if (done !== 1'b1 || busy !== 1'b0 || ready !== 1'b0 || result !== AW'(r) || ovf !== o) begin
        bad++;
        $display("FAIL %s hold: done=%0b busy=%0b ready=%0b result=%0d ovf=%0b want 1 0 0 %0d %0b",
                 tag, done, busy, ready, result, ovf, r, o);
      end
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    op_in = 2'd1;
    n_in  = 8'd3;
    valid = 1'b1;
    data  = 8'hAA;
    repeat (3) tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || ready !== 1'b0 || result !== '0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset: done=%0b busy=%0b ready=%0b result=%0d ovf=%0b want all 0",
               done, busy, ready, result, ovf);
    end
    rst   = 1'b0;
    start = 1'b0;
    valid = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0 || ready !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: busy=%0b ready=%0b done=%0b want 0 0 0", busy, ready, done);
    end
  endtask

  task automatic test_sum_basic();
    samp = '{10, 20, 30, 40};
    do_run(0, 4, 0, "sum4");
    total++;
    if (result !== 8'd100 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL sum4_value: result=%0d ovf=%0b want 100 0", result, ovf);
    end
    hold_done(0, 4, 2, "sum4");
  endtask

  task automatic test_overflow();
    samp = '{255, 255};
    do_run(0, 2, 0, "sum_wrap");
    total++;
    if (result !== 8'hFE || ovf !== 1'b1) begin
      bad++;
      $display("FAIL sum_wrap_value: result=%0h ovf=%0b want fe 1", result, ovf);
    end
    do_run(3, 2, 0, "sat");
    total++;
    if (result !== 8'hFF || ovf !== 1'b1) begin
      bad++;
      $display("FAIL sat_value: result=%0h ovf=%0b want ff 1", result, ovf);
    end
    hold_done(3, 2, 2, "sat");
  endtask

  task automatic test_max_min();
    samp = '{5, 200, 7};
    do_run(1, 3, 2, "max");
    total++;
    if (result !== 8'd200 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL max_value: result=%0d ovf=%0b want 200 0", result, ovf);
    end
    do_run(2, 3, 2, "min");
    total++;
    if (result !== 8'd5 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL min_value: result=%0d ovf=%0b want 5 0", result, ovf);
    end
  endtask

  task automatic test_zero_len();
    samp = '{};
    do_run(1, 0, 0, "zero_max");
    hold_done(1, 0, 2, "zero_max");
    do_run(0, 0, 0, "zero_sum");
  endtask

  task automatic test_reset_midrun();
    samp = '{200, 100, 50, 25};
    start = 1'b1;
    op_in = 2'd0;
    n_in  = 8'd4;
    tick();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      valid = 1'b1;
      data  = DW'(samp[k]);
      tick();
    end
    valid = 1'b0;
    start = 1'b1;
    op_in = 2'd1;
    n_in  = 8'd0;
    tick();
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || done !== 1'b0 || result !== 8'd44 || ovf !== 1'b1) begin
      bad++;
      $display("FAIL start_in_run: busy=%0b done=%0b result=%0d ovf=%0b want 1 0 44 1",
               busy, done, result, ovf);
    end
    rst   = 1'b1;
    start = 1'b1;
    valid = 1'b1;
    data  = 8'd9;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    valid = 1'b0;
    total++;
    if (busy !== 1'b0 || ready !== 1'b0 || done !== 1'b0 || result !== '0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL midrun_reset: busy=%0b ready=%0b done=%0b result=%0d ovf=%0b want all 0",
               busy, ready, done, result, ovf);
    end
    valid = 1'b1;
    tick();
    valid = 1'b0;
    total++;
    if (busy !== 1'b0 || result !== '0) begin
      bad++;
      $display("FAIL midrun_reset_idle: busy=%0b result=%0d want 0 0", busy, result);
    end
  endtask

  task automatic test_back_to_back();
    samp = '{3, 4};
    do_run(0, 2, 0, "b2b_first");
    start = 1'b1;
    op_in = 2'd2;
    n_in  = 8'd3;
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b1 || result !== '0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL b2b_restart: done=%0b busy=%0b result=%0d ovf=%0b want 0 1 0 0",
               done, busy, result, ovf);
    end
    samp = '{9, 2, 6};
    valid = 1'b1;
    data  = 8'd9;
    tick();
    total++;
    if (result !== 8'd9 || busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_held_start: result=%0d busy=%0b want 9 1", result, busy);
    end
    data = 8'd2;
    tick();
    data = 8'd6;
    op_in = 2'd0;
    n_in  = 8'd1;
    tick();
    valid = 1'b0;
    total++;
    if (done !== 1'b1 || result !== 8'd2 || busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_min: done=%0b result=%0d busy=%0b want 1 2 0", done, result, busy);
    end
    tick();
    start = 1'b0;
    total++;
    if (done !== 1'b0 || busy !== 1'b1 || result !== '0) begin
      bad++;
      $display("FAIL b2b_second_restart: done=%0b busy=%0b result=%0d want 0 1 0", done, busy, result);
    end
    valid = 1'b1;
    data  = 8'd77;
    tick();
    valid = 1'b0;
    total++;
    if (done !== 1'b1 || result !== 8'd77 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL b2b_one: done=%0b result=%0d ovf=%0b want 1 77 0", done, result, ovf);
    end
  endtask

  task automatic test_random();
    int op;
    int n;
    for (int run = 0; run < 40; run++) begin
      op = int'($urandom_range(0, 3));
      n  = int'($urandom_range(0, 8));
      samp = '{};
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 1) == 1) samp.push_back($urandom_range(150, 255));
        else samp.push_back($urandom_range(0, 255));
      end
      do_run(op, n, -1, "random");
      hold_done(op, n, int'($urandom_range(0, 2)), "random");
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    op_in = '0;
    n_in  = '0;
    valid = 1'b0;
    data  = '0;
    test_reset();
    test_sum_basic();
    test_overflow();
    test_max_min();
    test_zero_len();
    test_reset_midrun();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_accum_engine

// File: doc/accum_engine.md
ACCUM_ENGINE -- requirements
Module: accum_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning sample width (unsigned).
REQ-002 SHALL have parameter CNT_W, default 8, meaning sample-count width.
REQ-003 SHALL have parameter ACC_W, default 16, meaning result width; ACC_W >= DATA_W required.
REQ-004 SHALL have port clk_i  input  1  meaning single clock; all logic on rising edge.
REQ-005 SHALL have port rst_i  input  1  meaning reset, synchronous, active-high.
REQ-006 SHALL have port start_i  input  1  meaning begin a run; sampled only in IDLE or DONE.
REQ-007 SHALL have port op_i  input  2  meaning operation: 0 SUM, 1 MAX, 2 MIN, 3 SUM with saturation.
REQ-008 SHALL have port n_i  input  CNT_W  meaning number of samples in the run.
REQ-009 SHALL have port valid_i  input  1  meaning data_i carries a sample.
REQ-010 SHALL have port data_i  input  DATA_W  meaning sample value.
REQ-011 SHALL have port ready_o  output  1  meaning engine accepts a sample this cycle.
REQ-012 SHALL have port busy_o  output  1  meaning run in progress.
REQ-013 SHALL have port done_o  output  1  meaning result valid; held until next start or reset.
REQ-014 SHALL have port result_o  output  ACC_W  meaning accumulated result.
REQ-015 SHALL have port ovf_o  output  1  meaning wrap or saturation occurred during the run.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE.
REQ-017 SHALL, in IDLE or DONE with start_i=1, latch op_i and n_i, clear accumulator and ovf_o, deassert done_o, enter RUN next cycle.
REQ-018 SHALL, on start with n_i=0, go directly to DONE with result_o=0 (MAX/MIN included), ovf_o=0, done_o=1 next cycle.
REQ-019 SHALL assert ready_o=1 only in RUN; a sample is accepted on a cycle with valid_i=1 and ready_o=1.
REQ-020 SHALL ignore data_i while valid_i=0 (stall; no count change) and ignore start_i while in RUN.
REQ-021 SHALL, for SUM, add the zero-extended sample modulo 2^ACC_W and set ovf_o sticky on carry-out.
REQ-022 SHALL, for SAT, clamp to 2^ACC_W-1 on overflow and set ovf_o sticky.
REQ-023 SHALL, for MAX/MIN, load the first accepted sample as-is, then keep the larger/smaller; ovf_o stays 0.
REQ-024 SHALL count accepted samples; on acceptance of sample n (the last), enter DONE next cycle with result_o including that sample, done_o=1, busy_o=0 (latency 1 cycle after last handshake).
REQ-025 SHALL hold result_o, ovf_o and done_o stable in DONE until start_i or rst_i.
REQ-026 SHALL, in DONE with start_i=1, start the new run in the same way as IDLE (back-to-back runs, no idle cycle required).
REQ-027 SHALL keep result_o driven by the accumulator register at all times (intermediate values visible during RUN).
REQ-028 SHALL assert busy_o exactly while in RUN.

Reset
REQ-029 SHALL, on rst_i=1 at a clock edge, enter IDLE regardless of state, including mid-run, discarding the partial result.
REQ-030 SHALL reset values: result_o=0, ovf_o=0, done_o=0, busy_o=0, ready_o=0, sample counter=0, latched op=SUM.
REQ-031 SHALL give rst_i priority over start_i and valid_i in the same cycle.

Structure
REQ-032 SHALL place state enum (IDLE/RUN/DONE) and op enum (SUM/MAX/MIN/SAT) in shared package accum_pkg.
REQ-033 SHALL implement SUM/SAT arithmetic in one sub-module sat_add (ACC_W-bit add, carry-out, optional clamp).
REQ-034 SHALL register all outputs; no combinational path from data_i to result_o.

Verification
REQ-035 SHALL cover: defaults, op=SUM, n=4, samples 10,20,30,40 back-to-back -> done_o 1 cycle after last, result_o=100, ovf_o=0.
REQ-036 SHALL cover: op=SUM, n=2, samples 0xFF,0xFF with ACC_W=8 -> result_o=0xFE, ovf_o=1; same with op=SAT -> result_o=0xFF, ovf_o=1.
REQ-037 SHALL cover: op=MAX, n=3, samples 5,200,7 with valid_i gaps of 2 cycles -> result_o=200; op=MIN same data -> 5.
REQ-038 SHALL cover: n=0 start -> done_o=1 next cycle, result_o=0, no ready_o pulse.
REQ-039 SHALL cover: rst_i asserted after 2 of 4 samples -> next cycle IDLE, result_o=0, done_o=0; start_i during RUN ignored.
REQ-040 SHALL cover: start_i held in DONE -> new run begins, done_o drops, previous result cleared.
